seg_scan_controller: RTL

Sequencing controller for the 4-digit seven-segment display. It accepts a 13-bit binary value over a valid/ready handshake and converts it to four BCD digits with an iterative shift-add-3 engine. It commits the digits atomically and time-multiplexes the anodes at a programmable refresh rate. It sits between switch/counter logic and the board's segment/anode pins, and replaces ad-hoc per-digit modulo arithmetic.

---
 rtl/seg_scan_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - binary-to-BCD seven-segment scan controller
//
// Purpose: accepts an unsigned binary value over a valid/ready handshake,
// converts it to four BCD digits with an iterative shift-add-3 engine, commits
// the digits atomically and time-multiplexes the four anodes.
//
// Optional feature macro: BLANK_LEADING_ZEROS_EN
//   defined   - digits above the most-significant nonzero digit are blanked
//   undefined - all four digits are always shown
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-low reset
//   in_valid       in   requester has a value on in_value
//   in_value       in   [DATA_W-1:0] unsigned value to display
//   in_ready       out  controller can accept (IDLE only)
//   busy           out  conversion or commit in progress
//   segmentDisplay out  [6:0] cathodes {g,f,e,d,c,b,a}, active-low
//   an             out  [3:0] anodes, active-low
//   dp             out  decimal point, active-low, held off

module seg_scan_controller #(
  parameter int DATA_W      = 13,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_value,
  output logic              in_ready,
  output logic              busy,
  output logic [6:0]        segmentDisplay,
  output logic [3:0]        an,
  output logic              dp
);

  localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0]      CNT_LAST = 4'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [15:0]       r_bcd;
  logic [3:0]        r_cnt;
  logic [15:0]       r_digits;
  logic              r_in_ready;
  logic              r_busy;

  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_idx;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;

  logic [15:0]       w_adj;
  logic              w_tc;
  logic [3:0]        w_digit;
  logic              w_slot_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction: any BCD nibble >= 5 would overflow past 9 after the
  // upcoming doubling shift, so it is pre-biased by 3.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < 4; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM. The working registers are private to the FSM so the
  // displayed digits only change at COMMIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_digits   <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_shift    <= in_value;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_state    <= S_CONVERT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_CONVERT: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt            <= r_cnt + 4'd1;
          if (r_cnt == CNT_LAST) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_digits   <= r_bcd;
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BLANK_LEADING_ZEROS_EN
  logic [3:0] r_blank;
  logic [3:0] w_blank_mask;

  // A digit is blank when it and every digit above it are zero; the ones
  // digit is never blank so a value of zero still shows "0".
  always_comb begin
    w_blank_mask    = 4'b0000;
    w_blank_mask[3] = (r_bcd[15:12] == 4'd0);
    w_blank_mask[2] = w_blank_mask[3] && (r_bcd[11:8] == 4'd0);
    w_blank_mask[1] = w_blank_mask[2] && (r_bcd[7:4] == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_blank <= 4'b1110;
    end else if (r_state == S_COMMIT) begin
      r_blank <= w_blank_mask;
    end
  end

  assign w_slot_blank = r_blank[r_idx];
`else
  assign w_slot_blank = 1'b0;
`endif

  assign w_tc = (r_div == DIV_LAST);

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = r_digits[3:0];
      2'd1:    w_digit = r_digits[7:4];
      2'd2:    w_digit = r_digits[11:8];
      default: w_digit = r_digits[15:12];
    endcase
  end

  // Free-running scan. The outputs are registered from the current index and
  // digits, so a commit and an index advance on the same edge both show up
  // together in the next registered output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div <= '0;
      r_idx <= 2'd0;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_div <= w_tc ? '0 : r_div + DIV_W'(1);
      if (w_tc) begin
        r_idx <= r_idx + 2'd1;
      end
      case (r_idx)
        2'd0:    r_an <= 4'b1110;
        2'd1:    r_an <= 4'b1101;
        2'd2:    r_an <= 4'b1011;
        default: r_an <= 4'b0111;
      endcase
      r_seg <= w_slot_blank ? 7'b1111111 : decode(w_digit);
    end
  end

  assign in_ready       = r_in_ready;
  assign busy           = r_busy;
  assign segmentDisplay = r_seg;
  assign an             = r_an;
  assign dp             = 1'b1;

endmodule
